// File: rtl/pending_priority_arbiter.sv
// Sticky pending-request register feeding a one-index-per-transfer valid/ready
// output stage, served in fixed-priority or round-robin order.

module pending_cell (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q
);
  // A set in the same cycle as a clear keeps the bit: the request is served again.
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= (q & ~clr) | set;
  end
endmodule

module pending_priority_arbiter #(
  parameter int WIDTH   = 16,
  parameter int IDX_W   = 4,
  parameter int CNT_W   = 5,
  parameter int RR_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] pend_vec,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             all_clear
);

  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] winner;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] below_last;
  logic [WIDTH-1:0] search;
  logic             stage_free;
  logic             load;

  function automatic logic [IDX_W-1:0] highest_set(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  assign stage_free = !out_valid || out_ready;
  assign load       = stage_free && (pend_vec != '0);

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_lane
      pending_cell u_cell (
        .clk (clk),
        .rst (rst),
        .set (req_in[g]),
        .clr (clear_mask[g]),
        .q   (pend_vec[g])
      );
      assign below_last[g] = (IDX_W'(g) < last_idx);
    end
  endgenerate

  // Round-robin: indices below last_idx are searched first (descending); if
  // none is pending, the wrap portion is last_idx..WIDTH-1, again highest first.
  generate
    if (RR_MODE != 0) begin : g_rr
      logic [WIDTH-1:0] lower;
      assign lower  = pend_vec & below_last;
      assign search = (lower != '0) ? lower : pend_vec;
    end else begin : g_fixed
      assign search = pend_vec;
    end
  endgenerate

  assign winner = highest_set(search);

  always_comb begin
    clear_mask = '0;
    if (load) clear_mask[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      last_idx  <= '0;
    end else if (stage_free) begin
      if (pend_vec != '0) begin
        out_valid <= 1'b1;
        out_idx   <= winner;
        last_idx  <= winner;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < WIDTH; i++)
      pend_cnt = pend_cnt + CNT_W'(pend_vec[i]);
  end

  assign all_clear = !out_valid && (pend_vec == '0);

endmodule

// File: tb/tb_pending_priority_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with the same stimulus and
// scores each against its own behavioural model.

module tb_pending_priority_arbiter;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  req_in;
  logic          out_ready;

  logic          v0, v1;
  logic [3:0]    i0, i1;
  logic [W-1:0]  p0, p1;
  logic [4:0]    c0, c1;
  logic          a0, a1;

  int checks = 0;
  int fails  = 0;

  // behavioural model state, index 0 = fixed, 1 = round-robin
  logic [W-1:0] m_pend [2];
  logic         m_vld  [2];
  int           m_idx  [2];
  int           m_last [2];
  int           q0[$];
  int           q1[$];

  always #5 clk = ~clk;

  pending_priority_arbiter #(.WIDTH(W), .IDX_W(4), .CNT_W(5), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .req_in(req_in), .out_ready(out_ready),
    .out_valid(v0), .out_idx(i0), .pend_vec(p0), .pend_cnt(c0), .all_clear(a0));

  pending_priority_arbiter #(.WIDTH(W), .IDX_W(4), .CNT_W(5), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req_in(req_in), .out_ready(out_ready),
    .out_valid(v1), .out_idx(i1), .pend_vec(p1), .pend_cnt(c1), .all_clear(a1));

  // Fixed: highest pending index. Round-robin: walk down from last-1, wrapping.
  function automatic int pick(input logic [W-1:0] pend, input int last, input int mode);
    if (mode == 0) begin
      for (int i = W - 1; i >= 0; i--) if (pend[i]) return i;
    end else begin
      for (int k = 1; k <= W; k++) begin
        int j;
        j = (last + W - k) % W;
        if (pend[j]) return j;
      end
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_pend[m] = '0; m_vld[m] = 1'b0; m_idx[m] = 0; m_last[m] = 0;
        if (m == 0) q0.delete(); else q1.delete();
      end else begin
        logic [W-1:0] clr;
        clr = '0;
        if (!m_vld[m] || out_ready) begin
          if (m_pend[m] != '0) begin
            int w;
            w = pick(m_pend[m], m_last[m], m);
            m_vld[m] = 1'b1; m_idx[m] = w; m_last[m] = w; clr[w] = 1'b1;
            if (m == 0) q0.push_back(w); else q1.push_back(w);
          end else begin
            m_vld[m] = 1'b0;
          end
        end
        m_pend[m] = (m_pend[m] & ~clr) | req_in;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_dut(input int m, input logic v, input logic [3:0] idx,
                           input logic [W-1:0] pv, input logic [4:0] cnt, input logic ac);
    string t;
    t = (m == 0) ? "fix" : "rr";
    chk({t, ".out_valid"}, int'(v), int'(m_vld[m]));
    chk({t, ".out_idx"},   int'(idx), m_idx[m]);
    chk({t, ".pend_vec"},  int'(pv), int'(m_pend[m]));
    chk({t, ".pend_cnt"},  int'(cnt), $countones(m_pend[m]));
    chk({t, ".all_clear"}, int'(ac), int'(!m_vld[m] && m_pend[m] == '0));
    if (v && out_ready && !rst) begin
      int e;
      if (m == 0 ? q0.size() == 0 : q1.size() == 0) begin
        checks++; fails++;
        $display("FAIL %s.scoreboard at %0t: transfer of %0d with empty queue", t, $time, idx);
      end else begin
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        chk({t, ".transfer_idx"}, int'(idx), e);
      end
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, v0, i0, p0, c0, a0);
    check_dut(1, v1, i1, p1, c1, a1);
  end

  task automatic step(input logic [W-1:0] r, input logic rdy, input int n = 1);
    for (int k = 0; k < n; k++) begin
      req_in = r; out_ready = rdy;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    rst = 1'b1; req_in = '1; out_ready = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    step('0, 1'b1, 2);
    // fixed order from a single pulse
    step(16'h8421, 1'b1);
    step('0, 1'b1, 6);
    // backpressure with index 5 held, then a later higher request
    step(16'h0020, 1'b0);
    step('0, 1'b0, 2);
    step(16'h4000, 1'b0);
    step('0, 1'b0, 2);
    step('0, 1'b1, 4);
    // continuous requests on 3 and 12
    step(16'h1008, 1'b1, 8);
    step('0, 1'b1, 4);
    // re-request collision on bit 7
    step(16'h0080, 1'b1, 2);
    step('0, 1'b1, 4);
    // reset while a grant is held with three pending
    step(16'h001E, 1'b0);
    step('0, 1'b0, 2);
    rst = 1'b1; step(16'h0100, 1'b1);
    rst = 1'b0; step('0, 1'b1, 4);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      step(W'($urandom & $urandom & $urandom), 1'($urandom_range(0, 3) != 0));
    end
    rst = 1'b0;
    step('0, 1'b1, 40);
    chk("fix.queue_drained", q0.size(), 0);
    chk("rr.queue_drained",  q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
